// File: rtl/operand_fetch.sv
// Operand-fetch issue stage: holds one decoded instruction, reads both source
// operands from a registered-read register file and presents them to execute.
// A per-register pending-write scoreboard blocks RAW/WAW hazards until writeback
// retires the outstanding write.
module operand_fetch #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 4,
  parameter int unsigned OP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       in_rs1,
  input  logic [AW-1:0]       in_rs2,
  input  logic [AW-1:0]       in_rd,
  input  logic                in_rd_en,
  input  logic [OP_WIDTH-1:0] in_op,
  output logic                rf_available,
  output logic [AW-1:0]       rf_read_addr_a,
  output logic [AW-1:0]       rf_read_addr_b,
  input  logic [XLEN-1:0]     rf_read_data_a,
  input  logic [XLEN-1:0]     rf_read_data_b,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_op_a,
  output logic [XLEN-1:0]     out_op_b,
  output logic [AW-1:0]       out_rd,
  output logic                out_rd_en,
  output logic [OP_WIDTH-1:0] out_op
);

  localparam int unsigned NReg = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StCheck, StRead, StOut} state_e;

  state_e                r_state, w_state_next;
  logic [NReg-1:0]       r_pending, w_pending_next;
  logic [AW-1:0]         r_rs1, r_rs2, r_rd;
  logic                  r_rd_en;
  logic [OP_WIDTH-1:0]   r_op;
  logic [XLEN-1:0]       r_op_a, r_op_b;
  logic                  r_valid;
  logic                  r_avail;
  logic                  w_accept, w_issue, w_hazard;

  // Handshakes, hazard test and scoreboard next-state.
  always_comb begin
    in_ready = r_avail & ~flush &
               ((r_state == StIdle) | ((r_state == StOut) & out_ready));
    w_accept = in_valid & in_ready;
    w_issue  = (r_state == StOut) & out_ready & ~flush;
    // A source retiring this very cycle still counts as pending: the register
    // file returns the old value on the edge it is written.
    w_hazard = ((r_rs1 != '0) & r_pending[r_rs1]) |
               ((r_rs2 != '0) & r_pending[r_rs2]) |
               (r_rd_en & (r_rd != '0) & r_pending[r_rd]);
    w_pending_next = r_pending;
    if (wb_valid) w_pending_next[wb_addr] = 1'b0;
    // Set after clear so a same-edge set wins.
    if (w_issue & r_rd_en) w_pending_next[r_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  // FSM next-state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StCheck;
      StCheck: if (!w_hazard) w_state_next = StRead;
      StRead:  w_state_next = StOut;
      StOut:   if (w_issue) w_state_next = w_accept ? StCheck : StIdle;
      default: w_state_next = StIdle;
    endcase
    if (flush) w_state_next = StIdle;
  end

  // State, scoreboard, instruction latch and operand capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_rd_en   <= 1'b0;
      r_op      <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_valid   <= 1'b0;
      r_avail   <= 1'b0;
    end else begin
      r_avail   <= 1'b1;
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      if (w_accept) begin
        r_rs1   <= in_rs1;
        r_rs2   <= in_rs2;
        r_rd    <= in_rd;
        r_rd_en <= in_rd_en;
        r_op    <= in_op;
      end
      if ((r_state == StRead) && !flush) begin
        r_op_a  <= rf_read_data_a;
        r_op_b  <= rf_read_data_b;
        r_valid <= 1'b1;
      end
      if (flush || w_issue) r_valid <= 1'b0;
    end
  end

  assign rf_available   = r_avail;
  assign rf_read_addr_a = r_rs1;
  assign rf_read_addr_b = r_rs2;
  assign out_valid      = r_valid;
  assign out_op_a       = r_op_a;
  assign out_op_b       = r_op_b;
  assign out_rd         = r_rd;
  assign out_rd_en      = r_rd_en;
  assign out_op         = r_op;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a registered-read register-file model,
// a scoreboard of expected issued instructions, and per-scenario tasks.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_rd_en;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic [7:0]  in_op;
  logic        rf_available;
  logic [3:0]  rf_read_addr_a, rf_read_addr_b;
  logic [31:0] rf_read_data_a, rf_read_data_b;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready, out_rd_en;
  logic [31:0] out_op_a, out_op_b;
  logic [3:0]  out_rd;
  logic [7:0]  out_op;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic        en;
    logic [7:0]  op;
  } exp_t;
  exp_t sb[$];

  logic [31:0] regs [16];

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .AW(4), .OP_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en), .in_op(in_op),
    .rf_available(rf_available), .rf_read_addr_a(rf_read_addr_a),
    .rf_read_addr_b(rf_read_addr_b), .rf_read_data_a(rf_read_data_a),
    .rf_read_data_b(rf_read_data_b), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a),
    .out_op_b(out_op_b), .out_rd(out_rd), .out_rd_en(out_rd_en), .out_op(out_op)
  );

  // Register file: one-cycle registered read, a write returns old data that edge.
  always @(posedge clk) begin
    rf_read_data_a <= regs[rf_read_addr_a];
    rf_read_data_b <= regs[rf_read_addr_b];
    if (wb_valid && wb_addr != 4'd0) regs[wb_addr] <= wb_data;
  end

  // Issue monitor: an issue happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      exp_t got, e;
      got = {out_op_a, out_op_b, out_rd, out_rd_en, out_op};
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got a=%h b=%h rd=%0d, required no issue",
                 out_op_a, out_op_b, out_rd);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL issue_data: got a=%h b=%h rd=%0d en=%b op=%h, required a=%h b=%h rd=%0d en=%b op=%h",
                   got.a, got.b, got.rd, got.en, got.op, e.a, e.b, e.rd, e.en, e.op);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction until accepted (bounded); returns 1 ns after the accept edge.
  task automatic accept(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                        input logic en, input logic [7:0] op, input bit push,
                        input logic [31:0] ea, input logic [31:0] eb);
    bit done = 1'b0;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_en = en; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    end else if (push) begin
      sb.push_back({ea, eb, rd, en, op});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_vec++; if (rf_available !== 1'b0) begin n_err++; $display("FAIL rst_rf_avail: got %b required 0", rf_available); end
    n_vec++; if ({out_op_a, out_op_b, rf_read_addr_a, out_rd} !== 72'd0) begin n_err++; $display("FAIL rst_data: got a=%h b=%h addr=%0d rd=%0d required 0", out_op_a, out_op_b, rf_read_addr_a, out_rd); end
    reset = 1'b0;
    #1;
    n_vec++; if (rf_available !== 1'b0) begin n_err++; $display("FAIL rst_avail_early: got %b required 0", rf_available); end
    step();
    n_vec++; if (rf_available !== 1'b1) begin n_err++; $display("FAIL rst_avail_after: got %b required 1", rf_available); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    accept(4'd3, 4'd4, 4'd5, 1'b1, 8'h01, 1'b1, regs[3], regs[4]);
    n_vec++; if (out_valid !== 1'b0 || rf_read_addr_a !== 4'd3 || rf_read_addr_b !== 4'd4) begin n_err++; $display("FAIL basic_check: got v=%b a=%0d b=%0d required v=0 a=3 b=4", out_valid, rf_read_addr_a, rf_read_addr_b); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat1: got %b required 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_op_a !== 32'h11 || out_op_b !== 32'h22) begin n_err++; $display("FAIL basic_lat2: got v=%b a=%h b=%h required v=1 a=11 b=22", out_valid, out_op_a, out_op_b); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %b required 0", out_valid); end
  endtask

  // r5 is pending from test_basic; reading it must stall until writeback.
  task automatic test_raw();
    accept(4'd5, 4'd4, 4'd6, 1'b0, 8'h02, 1'b1, 32'hAB, regs[4]);
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL raw_stall: got %b required 0 (cycle %0d)", out_valid, k); end
    end
    wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 32'hAB;
    step();
    wb_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL raw_wb0: got %b required 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL raw_wb1: got %b required 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_op_a !== 32'hAB) begin n_err++; $display("FAIL raw_wb2: got v=%b a=%h required v=1 a=ab", out_valid, out_op_a); end
    step();
  endtask

  task automatic test_r0();
    for (int k = 0; k < 2; k++) begin
      accept(4'd0, 4'd0, 4'd0, 1'b1, 8'h03, 1'b1, 32'd0, 32'd0);
      step();
      step();
      n_vec++; if (out_valid !== 1'b1 || out_op_a !== 32'd0 || out_op_b !== 32'd0) begin n_err++; $display("FAIL r0_nostall: got v=%b a=%h b=%h required v=1 a=0 b=0 (pass %0d)", out_valid, out_op_a, out_op_b, k); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    accept(4'd3, 4'd4, 4'd7, 1'b1, 8'h44, 1'b1, regs[3], regs[4]);
    step();
    step();
    in_rs1 = 4'd3; in_rs2 = 4'd2; in_rd = 4'd8; in_rd_en = 1'b0; in_op = 8'h55; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (out_valid !== 1'b1 || out_op_a !== 32'h11 || out_rd !== 4'd7 || out_op !== 8'h44 || in_ready !== 1'b0) begin n_err++; $display("FAIL hold_stable: got v=%b a=%h rd=%0d op=%h rdy=%b required v=1 a=11 rd=7 op=44 rdy=0", out_valid, out_op_a, out_rd, out_op, in_ready); end
      step();
    end
    out_ready = 1'b1;
    sb.push_back({regs[3], regs[2], 4'd8, 1'b0, 8'h55});
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b required 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap0: got %b required 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap1: got %b required 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_op_b !== 32'h5A) begin n_err++; $display("FAIL b2b_valid: got v=%b b=%h required v=1 b=5a", out_valid, out_op_b); end
    step();
  endtask

  task automatic test_flush();
    // Flush while in READ.
    accept(4'd3, 4'd4, 4'd9, 1'b1, 8'h60, 1'b0, 32'd0, 32'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_read: got %b required 0", out_valid); end
    // Flush while in OUT, with out_ready high: no issue.
    out_ready = 1'b0;
    accept(4'd2, 4'd3, 4'd10, 1'b1, 8'h61, 1'b0, 32'd0, 32'd0);
    step();
    step();
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out: got %b required 0", out_valid); end
    // Flushed instructions never set r9/r10 pending.
    accept(4'd10, 4'd9, 4'd0, 1'b0, 8'h66, 1'b1, regs[10], regs[9]);
    step();
    step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_nopend: got %b required 1", out_valid); end
    step();
    // r7 stays pending across flushes until writeback.
    accept(4'd7, 4'd0, 4'd0, 1'b0, 8'h67, 1'b1, 32'h77, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_keep_pend: got %b required 0 (cycle %0d)", out_valid, k); end
    end
    wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
    step();
    wb_valid = 1'b0;
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_wb1: got %b required 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_op_a !== 32'h77) begin n_err++; $display("FAIL flush_wb2: got v=%b a=%h required v=1 a=77", out_valid, out_op_a); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    accept(4'd1, 4'd2, 4'd5, 1'b1, 8'h70, 1'b1, regs[1], regs[2]);
    step();
    step();
    step();
    out_ready = 1'b0;
    accept(4'd3, 4'd4, 4'd0, 1'b0, 8'h71, 1'b0, 32'd0, 32'd0);
    step();
    step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got %b required 1", out_valid); end
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || rf_available !== 1'b0 || out_op_a !== 32'd0 || rf_read_addr_a !== 4'd0) begin n_err++; $display("FAIL rmid_async: got v=%b rdy=%b avail=%b a=%h addr=%0d required all 0", out_valid, in_ready, rf_available, out_op_a, rf_read_addr_a); end
    reset = 1'b0;
    #1;
    n_vec++; if (rf_available !== 1'b0) begin n_err++; $display("FAIL rmid_avail_early: got %b required 0", rf_available); end
    step();
    n_vec++; if (rf_available !== 1'b1) begin n_err++; $display("FAIL rmid_avail: got %b required 1", rf_available); end
    out_ready = 1'b1;
    accept(4'd5, 4'd0, 4'd0, 1'b0, 8'h72, 1'b1, 32'hAB, 32'd0);
    step();
    step();
    n_vec++; if (out_valid !== 1'b1 || out_op_a !== 32'hAB) begin n_err++; $display("FAIL rmid_pend_clr: got v=%b a=%h required v=1 a=ab", out_valid, out_op_a); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = i * 32'h01010101;
    regs[2] = 32'h5A; regs[3] = 32'h11; regs[4] = 32'h22;
    flush = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_en = 1'b0;
    in_op = '0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_raw();
    test_r0();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
